// File: rtl/rf_pkg.sv
// Shared types for the register-file write scheduler.
// Holds the writeback request bundle and the PC register index.
package rf_pkg;

    localparam int RF_SIZE       = 32;
    localparam int RF_AMOUNT_REG = 4;

    localparam logic [RF_AMOUNT_REG-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [RF_AMOUNT_REG-1:0] ra;
        logic [RF_SIZE-1:0]       wd;
    } wb_req_t;

endpackage

// File: rtl/rf_write_scheduler_wb_fifo.sv
// Synchronous FIFO buffering load-return writebacks.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i/data_o,
//        full_o, empty_o, count_o (0..DEPTH).
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Merges ALU and buffered load writebacks onto the single RF write port,
// redirects R15 writes to the PC port and tracks pending destinations.
// Ports: CLK, RST; ALU_* source; MEM_* load source with MEM_READY;
//        ISSUE_* from decode; WE3/RA3/WD3 RF port; PC_WE/PC_WD;
//        PENDING scoreboard; OCCUPANCY of the load FIFO.
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int SIZE       = RF_SIZE,
    parameter int AMOUNT_REG = RF_AMOUNT_REG,
    parameter int DEPTH      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ALU_VALID,
    input  logic [AMOUNT_REG-1:0]    ALU_RA,
    input  logic [SIZE-1:0]          ALU_WD,
    input  logic                     MEM_VALID,
    output logic                     MEM_READY,
    input  logic [AMOUNT_REG-1:0]    MEM_RA,
    input  logic [SIZE-1:0]          MEM_WD,
    input  logic                     ISSUE_VALID,
    input  logic [AMOUNT_REG-1:0]    ISSUE_RA,
    output logic                     WE3,
    output logic [AMOUNT_REG-1:0]    RA3,
    output logic [SIZE-1:0]          WD3,
    output logic                     PC_WE,
    output logic [SIZE-1:0]          PC_WD,
    output logic [2**AMOUNT_REG-1:0] PENDING,
    output logic [$clog2(DEPTH):0]   OCCUPANCY
);

    localparam int NREG = 2**AMOUNT_REG;

    wb_req_t mem_req, alu_req, head, sel;
    logic    fifo_full, fifo_empty, push, pop, sel_valid;

    logic                  we3_q, we3_d;
    logic [AMOUNT_REG-1:0] ra3_q, ra3_d;
    logic [SIZE-1:0]       wd3_q, wd3_d;
    logic                  pc_we_q, pc_we_d;
    logic [SIZE-1:0]       pc_wd_q, pc_wd_d;
    logic [NREG-1:0]       pending_q, pending_d;

    assign mem_req = '{ra: MEM_RA, wd: MEM_WD};
    assign alu_req = '{ra: ALU_RA, wd: ALU_WD};

    // Ready looks only at full, so a same-cycle pop never frees a slot.
    assign MEM_READY = !fifo_full;
    assign push      = MEM_VALID && !fifo_full;

    // ALU always wins; the FIFO head drains only on ALU-idle cycles.
    assign sel_valid = ALU_VALID || !fifo_empty;
    assign pop       = !ALU_VALID && !fifo_empty;
    assign sel       = ALU_VALID ? alu_req : head;

    wb_fifo #(
        .W     ($bits(wb_req_t)),
        .DEPTH (DEPTH)
    ) u_load_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .data_i  (mem_req),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (OCCUPANCY)
    );

    always_comb begin
        we3_d     = 1'b0;
        pc_we_d   = 1'b0;
        ra3_d     = ra3_q;
        wd3_d     = wd3_q;
        pc_wd_d   = pc_wd_q;
        pending_d = pending_q;
        if (sel_valid) begin
            if (sel.ra == PC_REG) begin
                pc_we_d = 1'b1;
                pc_wd_d = sel.wd;
            end else begin
                we3_d = 1'b1;
                ra3_d = sel.ra;
                wd3_d = sel.wd;
            end
            pending_d[sel.ra] = 1'b0;
        end
        // Applied after the clear: a new producer outranks the retiring one.
        if (ISSUE_VALID && ISSUE_RA != PC_REG) begin
            pending_d[ISSUE_RA] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            we3_q     <= 1'b0;
            ra3_q     <= '0;
            wd3_q     <= '0;
            pc_we_q   <= 1'b0;
            pc_wd_q   <= '0;
            pending_q <= '0;
        end else begin
            we3_q     <= we3_d;
            ra3_q     <= ra3_d;
            wd3_q     <= wd3_d;
            pc_we_q   <= pc_we_d;
            pc_wd_q   <= pc_wd_d;
            pending_q <= pending_d;
        end
    end

    assign WE3     = we3_q;
    assign RA3     = ra3_q;
    assign WD3     = wd3_q;
    assign PC_WE   = pc_we_q;
    assign PC_WD   = pc_wd_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: vector table plus
// hand-written full-FIFO and mid-traffic reset sequences.
module tb_rf_write_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ALU_VALID;
    logic [3:0]  ALU_RA;
    logic [31:0] ALU_WD;
    logic        MEM_VALID;
    logic        MEM_READY;
    logic [3:0]  MEM_RA;
    logic [31:0] MEM_WD;
    logic        ISSUE_VALID;
    logic [3:0]  ISSUE_RA;
    logic        WE3;
    logic [3:0]  RA3;
    logic [31:0] WD3;
    logic        PC_WE;
    logic [31:0] PC_WD;
    logic [15:0] PENDING;
    logic [2:0]  OCCUPANCY;

    int tests = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    rf_write_scheduler #(
        .SIZE       (32),
        .AMOUNT_REG (4),
        .DEPTH      (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ALU_VALID   (ALU_VALID),
        .ALU_RA      (ALU_RA),
        .ALU_WD      (ALU_WD),
        .MEM_VALID   (MEM_VALID),
        .MEM_READY   (MEM_READY),
        .MEM_RA      (MEM_RA),
        .MEM_WD      (MEM_WD),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_RA    (ISSUE_RA),
        .WE3         (WE3),
        .RA3         (RA3),
        .WD3         (WD3),
        .PC_WE       (PC_WE),
        .PC_WD       (PC_WD),
        .PENDING     (PENDING),
        .OCCUPANCY   (OCCUPANCY)
    );

    typedef struct {
        logic        av;
        logic [3:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  mr;
        logic [31:0] md;
        logic        iv;
        logic [3:0]  ir;
        logic        we;
        logic [3:0]  ra;
        logic [31:0] wd;
        logic        pwe;
        logic [31:0] pwd;
        logic [15:0] pend;
        logic [2:0]  occ;
        logic        rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ALU_VALID   = 1'b0;
        ALU_RA      = 4'd0;
        ALU_WD      = 32'h0;
        MEM_VALID   = 1'b0;
        MEM_RA      = 4'd0;
        MEM_WD      = 32'h0;
        ISSUE_VALID = 1'b0;
        ISSUE_RA    = 4'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(
        input logic av, input logic [3:0] ar, input logic [31:0] ad,
        input logic mv, input logic [3:0] mr, input logic [31:0] md,
        input logic iv, input logic [3:0] ir,
        input logic we, input logic [3:0] ra, input logic [31:0] wd,
        input logic pwe, input logic [31:0] pwd,
        input logic [15:0] pend, input logic [2:0] occ, input logic rdy);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md;
        v.iv = iv; v.ir = ir;
        v.we = we; v.ra = ra; v.wd = wd;
        v.pwe = pwe; v.pwd = pwd;
        v.pend = pend; v.occ = occ; v.rdy = rdy;
        return v;
    endfunction

    initial begin
        // inputs: alu(v,ra,wd) mem(v,ra,wd) issue(v,ra)
        // expect: we3 ra3 wd3 pc_we pc_wd pending occ ready
        vecs[0]  = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3,
                      1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 16'h0008, 3'd0, 1'b1);
        vecs[1]  = mk(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0, 16'h0000, 3'd0, 1'b1);
        vecs[2]  = mk(1'b1, 4'd1, 32'h11, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0,
                      1'b1, 4'd1, 32'h11, 1'b0, 32'h0, 16'h0000, 3'd1, 1'b1);
        vecs[3]  = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b1, 4'd5, 32'h55, 1'b0, 32'h0, 16'h0000, 3'd0, 1'b1);
        vecs[4]  = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b0, 4'd5, 32'h55, 1'b0, 32'h0, 16'h0000, 3'd0, 1'b1);
        vecs[5]  = mk(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h100, 1'b1, 4'd15,
                      1'b0, 4'd5, 32'h55, 1'b0, 32'h0, 16'h0000, 3'd1, 1'b1);
        vecs[6]  = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b0, 4'd5, 32'h55, 1'b1, 32'h100, 16'h0000, 3'd0, 1'b1);
        vecs[7]  = mk(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'hA7, 1'b1, 4'd7,
                      1'b0, 4'd5, 32'h55, 1'b0, 32'h100, 16'h0080, 3'd1, 1'b1);
        vecs[8]  = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                      1'b1, 4'd7, 32'hA7, 1'b0, 32'h100, 16'h0080, 3'd0, 1'b1);
        vecs[9]  = mk(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b1, 4'd7, 32'h77, 1'b0, 32'h100, 16'h0000, 3'd0, 1'b1);
        vecs[10] = mk(1'b1, 4'd15, 32'h200, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0,
                      1'b0, 4'd7, 32'h77, 1'b1, 32'h200, 16'h0000, 3'd1, 1'b1);
        vecs[11] = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b1, 4'd2, 32'h22, 1'b0, 32'h200, 16'h0000, 3'd0, 1'b1);
        vecs[12] = mk(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h44, 1'b0, 4'd0,
                      1'b0, 4'd2, 32'h22, 1'b0, 32'h200, 16'h0000, 3'd1, 1'b1);
        vecs[13] = mk(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0,
                      1'b1, 4'd4, 32'h44, 1'b0, 32'h200, 16'h0000, 3'd1, 1'b1);
        vecs[14] = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                      1'b1, 4'd6, 32'h66, 1'b0, 32'h200, 16'h0000, 3'd0, 1'b1);

        idle();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_we3", 32'(WE3), 32'd0);
        check("rst_ra3", 32'(RA3), 32'd0);
        check("rst_wd3", WD3, 32'd0);
        check("rst_pcwe", 32'(PC_WE), 32'd0);
        check("rst_pcwd", PC_WD, 32'd0);
        check("rst_pend", 32'(PENDING), 32'd0);
        check("rst_occ", 32'(OCCUPANCY), 32'd0);
        check("rst_ready", 32'(MEM_READY), 32'd1);

        for (int i = 0; i < 15; i++) begin
            ALU_VALID   = vecs[i].av;
            ALU_RA      = vecs[i].ar;
            ALU_WD      = vecs[i].ad;
            MEM_VALID   = vecs[i].mv;
            MEM_RA      = vecs[i].mr;
            MEM_WD      = vecs[i].md;
            ISSUE_VALID = vecs[i].iv;
            ISSUE_RA    = vecs[i].ir;
            tick();
            check($sformatf("v%0d_we3", i), 32'(WE3), 32'(vecs[i].we));
            check($sformatf("v%0d_ra3", i), 32'(RA3), 32'(vecs[i].ra));
            check($sformatf("v%0d_wd3", i), WD3, vecs[i].wd);
            check($sformatf("v%0d_pcwe", i), 32'(PC_WE), 32'(vecs[i].pwe));
            check($sformatf("v%0d_pcwd", i), PC_WD, vecs[i].pwd);
            check($sformatf("v%0d_pend", i), 32'(PENDING), 32'(vecs[i].pend));
            check($sformatf("v%0d_occ", i), 32'(OCCUPANCY), 32'(vecs[i].occ));
            check($sformatf("v%0d_rdy", i), 32'(MEM_READY), 32'(vecs[i].rdy));
        end
        idle();

        // Fill the FIFO while the ALU hogs the port.
        ALU_VALID = 1'b1;
        ALU_RA    = 4'd1;
        for (int k = 0; k < 4; k++) begin
            ALU_WD    = 32'h1000 + 32'(k);
            MEM_VALID = 1'b1;
            MEM_RA    = 4'(8 + k);
            MEM_WD    = 32'h80 + 32'(k);
            tick();
            check($sformatf("fill%0d_occ", k), 32'(OCCUPANCY), 32'(k + 1));
            check($sformatf("fill%0d_alu", k), WD3, 32'h1000 + 32'(k));
        end
        check("full_ready", 32'(MEM_READY), 32'd0);
        MEM_RA = 4'd12;
        MEM_WD = 32'hC0;
        ALU_WD = 32'h2000;
        tick();
        check("full_hold_occ", 32'(OCCUPANCY), 32'd4);
        check("full_hold_ready", 32'(MEM_READY), 32'd0);

        ALU_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic rdy_at_edge;
            rdy_at_edge = MEM_READY;
            tick();
            if (rdy_at_edge) MEM_VALID = 1'b0;
            check($sformatf("drain%0d_we3", k), 32'(WE3), 32'd1);
            check($sformatf("drain%0d_ra3", k), 32'(RA3),
                  (k < 4) ? 32'(8 + k) : 32'd12);
            check($sformatf("drain%0d_wd3", k), WD3,
                  (k < 4) ? 32'h80 + 32'(k) : 32'hC0);
        end
        check("drain_mem_v", 32'(MEM_VALID), 32'd0);
        check("drain_occ", 32'(OCCUPANCY), 32'd0);
        tick();
        check("drain_idle_we3", 32'(WE3), 32'd0);

        // Reset in the middle of traffic with three queued loads.
        ALU_VALID   = 1'b1;
        ALU_RA      = 4'd2;
        ALU_WD      = 32'h3;
        ISSUE_VALID = 1'b1;
        ISSUE_RA    = 4'd9;
        for (int k = 0; k < 3; k++) begin
            MEM_VALID = 1'b1;
            MEM_RA    = 4'(4 + k);
            MEM_WD    = 32'h40 + 32'(k);
            tick();
        end
        check("pre_rst_occ", 32'(OCCUPANCY), 32'd3);
        check("pre_rst_pend", 32'(PENDING), 32'h0200);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        idle();
        check("mrst_occ", 32'(OCCUPANCY), 32'd0);
        check("mrst_pend", 32'(PENDING), 32'd0);
        check("mrst_we3", 32'(WE3), 32'd0);
        check("mrst_pcwe", 32'(PC_WE), 32'd0);
        check("mrst_ready", 32'(MEM_READY), 32'd1);
        tick();
        check("post_rst_we3", 32'(WE3), 32'd0);
        check("post_rst_occ", 32'(OCCUPANCY), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Write-side companion to the pipelined core's register file. It merges writeback traffic into the register file's single write port (WE3/RA3/WD3).
- Two writeback sources: the single-cycle ALU path and the variable-latency load path, which is buffered in a small FIFO.
- Keeps a per-register pending scoreboard for decode hazard stalls.
- Redirects writes to R15 onto a separate PC-write port, because the register file never stores R15.

Parameters:
- SIZE, 32, data width of a register.
- AMOUNT_REG, 4, register address width (2**AMOUNT_REG registers).
- DEPTH, 4, load-return FIFO entries (power of two, >=2).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- ALU_VALID  in  1  ALU result valid this cycle (always accepted).
- ALU_RA  in  AMOUNT_REG  ALU destination register.
- ALU_WD  in  SIZE  ALU result.
- MEM_VALID  in  1  load return valid.
- MEM_READY  out  1  load FIFO can accept (=!full).
- MEM_RA  in  AMOUNT_REG  load destination register.
- MEM_WD  in  SIZE  load data.
- ISSUE_VALID  in  1  decode issued an instruction with a destination.
- ISSUE_RA  in  AMOUNT_REG  that destination.
- WE3  out  1  register file write enable.
- RA3  out  AMOUNT_REG  register file write address.
- WD3  out  SIZE  register file write data.
- PC_WE  out  1  R15 write strobe to fetch.
- PC_WD  out  SIZE  new PC value.
- PENDING  out  2**AMOUNT_REG  bit r = register r has an outstanding write.
- OCCUPANCY  out  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset, synchronous and active-high:
  - FIFO empty; OCCUPANCY=0; MEM_READY=1 in the cycle after RST deasserts.
  - PENDING=0.
  - WE3=0, RA3=0, WD3=0, PC_WE=0, PC_WD=0.
  - RST wins over every same-cycle event. In-flight FIFO entries are discarded.
- Enqueue: on MEM_VALID && MEM_READY, push {MEM_RA, MEM_WD}.
  - MEM_READY depends only on full. A pop in the same cycle does not free a slot for that cycle's push.
  - When full, MEM_VALID is ignored and the source must hold its data.
- Arbitration, once per cycle:
  - ALU_VALID has priority and its write is selected.
  - Otherwise, if the FIFO is non-empty, the head is popped and selected.
  - Otherwise nothing is selected.
  - An ALU write never starves the FIFO beyond consecutive ALU cycles; the load source is throttled via MEM_READY. This is accepted.
- Output latency: selected write appears on the registered outputs one cycle later.
  - Destination != 15: WE3=1, RA3, WD3 driven; PC_WE=0.
  - Destination == 15: PC_WE=1, PC_WD driven; WE3=0. RA3/WD3 hold their previous values.
  - With no selection, WE3=0 and PC_WE=0. RA3/WD3 hold.
- Enqueue and pop in the same cycle on a non-full FIFO: OCCUPANCY is unchanged and order is preserved. Pointers wrap modulo DEPTH.
- Empty FIFO plus same-cycle MEM push: no bypass. The entry is popped the next cycle at the earliest.
- Scoreboard:
  - ISSUE_VALID sets PENDING[ISSUE_RA] at the next edge.
  - A selected write clears PENDING[dest] at the edge where WE3/PC_WE is registered.
  - Set and clear of the same register in the same cycle: set wins, because the newer producer is outstanding.
  - ISSUE_RA==15 is ignored and PENDING[15] stays 0.
  - Set with PENDING already 1 stays 1. Single outstanding writer per register is the decode contract.
- Width: data is passed unmodified; no arithmetic. OCCUPANCY ranges 0..DEPTH.

Decomposition:
- Shared package rf_pkg:
  - localparam PC_REG = 4'd15.
  - typedef wb_req_t {logic [AMOUNT_REG-1:0] ra; logic [SIZE-1:0] wd;}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count. It is instantiated once for the load path.
- Arbiter, output registers and scoreboard live in rf_write_scheduler.

Test Plan:
- Reset: assert RST 2 cycles mid-traffic with 3 FIFO entries -> next cycle OCCUPANCY=0, PENDING=0, WE3=0, PC_WE=0, MEM_READY=1.
- ALU write: ALU_VALID, ALU_RA=3, ALU_WD=0xDEADBEEF, with ISSUE to r3 one cycle earlier -> next cycle WE3=1, RA3=3, WD3=0xDEADBEEF; PENDING[3] clears at that edge.
- Priority: ALU_VALID and MEM_VALID (r5, 0x55) together on an empty FIFO -> ALU write first, load write (RA3=5, WD3=0x55) the following cycle.
- Full FIFO: 4 loads with ALU_VALID held high -> OCCUPANCY=4, MEM_READY=0. The 5th load is held and not lost. Drop ALU_VALID -> 4 writes in push order on consecutive cycles.
- R15 redirect: load to r15 with data 0x00000100 -> PC_WE=1, PC_WD=0x100, WE3=0; PENDING[15] stays 0.
- Set/clear collision: ISSUE_RA=7 in the same cycle as the write to r7 is selected -> PENDING[7]=1 afterwards. A later write to r7 clears it.
